// File: rtl/dot_matrix_scan_capture.sv
// dot_matrix_scan_capture: rebuilds a 64-bit frame from an 8x8 row-scanned matrix bus, checks row order and dwell time.
// Latency: pin change to sample point is 2 + SETTLE_CYC cycles; o_fFrame follows the row-7 sample by one cycle.
// Backpressure: none; a passive monitor that never stalls the scan source and drops nothing it can sample.
module dot_matrix_scan_capture #(
  parameter int SETTLE_CYC  = 16,
  parameter int TIMEOUT_CYC = 131071
) (
  input  logic        i_Clk,
  input  logic        i_Rst,
  input  logic [7:0]  i_DM_Row,
  input  logic [7:0]  i_DM_Col,
  output logic [63:0] o_Frame,
  output logic        o_fFrame,
  output logic        o_fErr,
  output logic        o_Locked,
  output logic [2:0]  o_RowIdx
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] SAMPLE_AT = CW'(SETTLE_CYC - 1);
  localparam logic [CW-1:0] CNT_MAX   = CW'(TIMEOUT_CYC);

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    CAPTURE = 2'd1,
    PUBLISH = 2'd2
  } state_t;

  // Two-flop synchronisers plus one extra row stage that the stability counter tracks.
  logic [7:0]    row_s1_q, row_s2_q, prev_row_q;
  logic [7:0]    col_s1_q, col_s2_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          row_same;
  logic          sample_pt;
  logic          timeout_pt;
  logic [2:0]    row_k;

  state_t        state_q;
  logic [7:0]    exp_q;
  logic [63:0]   frame_buf_q;

  // Synchronise the asynchronous pins; prev_row_q is the row the counter measures.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      row_s1_q   <= '0;
      row_s2_q   <= '0;
      prev_row_q <= '0;
      col_s1_q   <= '0;
      col_s2_q   <= '0;
    end else begin
      row_s1_q   <= i_DM_Row;
      row_s2_q   <= row_s1_q;
      prev_row_q <= row_s2_q;
      col_s1_q   <= i_DM_Col;
      col_s2_q   <= col_s1_q;
    end
  end

  // Stability counter: restart on any synced row change, otherwise count up and saturate.
  always_comb begin
    row_same = (row_s2_q == prev_row_q);
    cnt_d    = cnt_q;
    if (!row_same) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Sample once per dwell when the row has been stable SETTLE_CYC cycles; timeout fires as the count tops out.
  always_comb begin
    sample_pt  = (cnt_q == SAMPLE_AT);
    timeout_pt = row_same && (cnt_q == CNT_MAX - CW'(1));
    row_k      = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (prev_row_q[i]) begin
        row_k = 3'(i);
      end
    end
  end

  // Scan-order FSM with registered outputs; a row matching the one-hot expectation is by construction valid.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q     <= HUNT;
      exp_q       <= '0;
      frame_buf_q <= '0;
      o_Frame     <= '0;
      o_fFrame    <= 1'b0;
      o_fErr      <= 1'b0;
      o_Locked    <= 1'b0;
      o_RowIdx    <= '0;
    end else begin
      o_fFrame <= 1'b0;
      o_fErr   <= 1'b0;
      case (state_q)
        HUNT: begin
          if (sample_pt && (prev_row_q == 8'h01)) begin
            frame_buf_q[7:0] <= col_s2_q;
            o_RowIdx         <= 3'd0;
            exp_q            <= 8'h02;
            state_q          <= CAPTURE;
            o_Locked         <= 1'b1;
          end
        end
        CAPTURE: begin
          if (sample_pt) begin
            if (prev_row_q == exp_q) begin
              frame_buf_q[{row_k, 3'b000} +: 8] <= col_s2_q;
              o_RowIdx <= row_k;
              exp_q    <= {exp_q[6:0], exp_q[7]};
              if (row_k == 3'd7) begin
                state_q <= PUBLISH;
              end
            end else begin
              o_fErr      <= 1'b1;
              o_Locked    <= 1'b0;
              frame_buf_q <= '0;
              state_q     <= HUNT;
            end
          end else if (timeout_pt) begin
            o_fErr      <= 1'b1;
            o_Locked    <= 1'b0;
            frame_buf_q <= '0;
            state_q     <= HUNT;
          end
        end
        PUBLISH: begin
          o_Frame  <= frame_buf_q;
          o_fFrame <= 1'b1;
          exp_q    <= 8'h01;
          state_q  <= CAPTURE;
        end
        default: begin
          o_Locked <= 1'b0;
          state_q  <= HUNT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dot_matrix_scan_capture.sv
// Bench for dot_matrix_scan_capture: directed scans checked every cycle against a pin-history model.
// Latency: model decides from raw pin runs (run of 16 identical pin values -> sample two edges later).
// Backpressure: not applicable; the bench drives pins freely on the falling edge.
module tb_dot_matrix_scan_capture;

  localparam int SETTLE = 16;
  localparam int TMO    = 1000;
  localparam int HSZ    = 16384;

  logic        i_Clk = 1'b0;
  logic        i_Rst;
  logic [7:0]  i_DM_Row;
  logic [7:0]  i_DM_Col;
  logic [63:0] o_Frame;
  logic        o_fFrame;
  logic        o_fErr;
  logic        o_Locked;
  logic [2:0]  o_RowIdx;

  int n_checks = 0;
  int n_errs   = 0;

  dot_matrix_scan_capture #(
    .SETTLE_CYC (SETTLE),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .i_Clk   (i_Clk),
    .i_Rst   (i_Rst),
    .i_DM_Row(i_DM_Row),
    .i_DM_Col(i_DM_Col),
    .o_Frame (o_Frame),
    .o_fFrame(o_fFrame),
    .o_fErr  (o_fErr),
    .o_Locked(o_Locked),
    .o_RowIdx(o_RowIdx)
  );

  always #10 i_Clk = ~i_Clk;

  // ---------------- model: pin history, run lengths, frame assembly ----------------
  // Entry j+3 holds the pins captured at edge j; entries 0..2 stand for the reset-cleared pipeline.
  logic [7:0]  prow [HSZ];
  logic [7:0]  pcol [HSZ];
  int          rl   [HSZ];
  int          mE;
  int          m_st;          // 0 hunting, 1 capturing, 2 publishing
  logic [2:0]  m_k;
  logic [2:0]  m_idx;
  logic [7:0]  m_buf [8];
  logic [63:0] m_frame;
  logic        m_ff, m_err;

  int ff_q[$];
  int err_q[$];
  int lock_q[$];
  logic lock_prev = 1'b0;

  task automatic model_reset();
    for (int j = 0; j < 3; j++) begin
      prow[j] = 8'h00;
      pcol[j] = 8'h00;
      rl[j]   = j + 1;
    end
    for (int j = 0; j < 8; j++) m_buf[j] = 8'h00;
    mE      = 0;
    m_st    = 0;
    m_k     = 3'd0;
    m_idx   = 3'd0;
    m_frame = 64'h0;
    m_ff    = 1'b0;
    m_err   = 1'b0;
  endtask

  task automatic model_step(input logic [7:0] r, input logic [7:0] c);
    int         i;
    logic       smp, tmo;
    logic [7:0] srow, scol, want;
    i = mE + 3;
    if (i >= HSZ) begin
      $display("FAIL history_overflow: edge %0d beyond model capacity %0d", mE, HSZ);
      $fatal(1, "model history exhausted");
    end
    prow[i] = r;
    pcol[i] = c;
    rl[i]   = (r == prow[i-1]) ? rl[i-1] + 1 : 1;
    // A row held for exactly SETTLE edges is acted on three edges after its last counted edge.
    smp  = (rl[i-3] == SETTLE);
    srow = prow[i-3];
    scol = pcol[i-2];
    tmo  = (rl[i-2] == TMO + 1);
    want = 8'h01 << m_k;
    m_ff  = 1'b0;
    m_err = 1'b0;
    if (m_st == 2) begin
      for (int j = 0; j < 8; j++) m_frame[8*j +: 8] = m_buf[j];
      m_ff = 1'b1;
      m_st = 1;
      m_k  = 3'd0;
    end else if (smp && m_st == 0) begin
      if (srow == 8'h01) begin
        m_buf[0] = scol;
        m_idx    = 3'd0;
        m_k      = 3'd1;
        m_st     = 1;
      end
    end else if (smp && m_st == 1) begin
      if (srow == want) begin
        m_buf[m_k] = scol;
        m_idx      = m_k;
        if (m_k == 3'd7) m_st = 2;
        else             m_k  = m_k + 3'd1;
      end else begin
        m_err = 1'b1;
        m_st  = 0;
      end
    end else if (tmo && m_st == 1) begin
      m_err = 1'b1;
      m_st  = 0;
    end
    mE = mE + 1;
  endtask

  // Per-cycle comparison, sampled 1 time unit after each rising edge.
  initial begin
    model_reset();
    forever begin
      @(posedge i_Clk);
      #1;
      if (i_Rst) begin
        model_reset();
      end else begin
        model_step(i_DM_Row, i_DM_Col);
        if (o_fFrame) ff_q.push_back(mE - 1);
        if (o_fErr) err_q.push_back(mE - 1);
        if (o_Locked && !lock_prev) lock_q.push_back(mE - 1);
      end
      lock_prev = o_Locked;
      n_checks++;
      if ({o_Frame, o_fFrame, o_fErr, o_Locked, o_RowIdx} !==
          {m_frame, m_ff, m_err, (m_st != 0), m_idx}) begin
        n_errs++;
        $display("FAIL cycle_cmp edge=%0d: got frame=%h ff=%b err=%b lock=%b idx=%0d, want frame=%h ff=%b err=%b lock=%b idx=%0d",
                 mE - 1, o_Frame, o_fFrame, o_fErr, o_Locked, o_RowIdx,
                 m_frame, m_ff, m_err, (m_st != 0), m_idx);
      end
    end
  end

  // ---------------- literal checks ----------------
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errs++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  task automatic chk_int(input string nm, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_errs++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask

  // ---------------- stimulus ----------------
  int last_p;
  int p01;

  task automatic dwell(input logic [7:0] r, input logic [7:0] c, input int n);
    i_DM_Row = r;
    i_DM_Col = c;
    last_p   = mE;
    repeat (n) @(negedge i_Clk);
  endtask

  task automatic scan_frame(input int kind, input bit scramble, input bit glitch);
    logic [7:0] r, c;
    for (int k = 0; k < 8; k++) begin
      r = 8'h01 << k;
      c = (kind == 0) ? 8'(8'h11 * (k + 1)) : 8'(8'hC0 + k);
      if (k == 0) p01 = mE;
      if (glitch && k == 2) begin
        dwell(r, c, 6);
        dwell(8'h40, 8'h5A, 5);
        dwell(r, c, 89);
      end else if (scramble) begin
        dwell(r, c, 60);
        i_DM_Col = ~c;
        repeat (40) @(negedge i_Clk);
      end else begin
        dwell(r, c, 100);
      end
    end
  endtask

  initial begin
    int n0, f0, p_first, p_bad;
    i_Rst    = 1'b1;
    i_DM_Row = 8'h00;
    i_DM_Col = 8'h00;
    repeat (3) @(negedge i_Clk);
    chk("reset_frame", o_Frame, 64'h0);
    chk("reset_flags", {61'h0, o_fFrame, o_fErr, o_Locked}, 64'h0);
    i_Rst = 1'b0;

    // 1: clean frame, columns scrambled after the sample point
    n0 = err_q.size();
    f0 = ff_q.size();
    scan_frame(0, 1'b1, 1'b0);
    chk_int("t1_lock_latency", (lock_q.size() > 0) ? lock_q[0] - p01 : -1, 18);
    chk_int("t1_frame_pulses", ff_q.size() - f0, 1);
    chk_int("t1_frame_pulse_edge", (ff_q.size() > f0) ? ff_q[f0] - p01 : -1, 719);
    chk_int("t1_no_errors", err_q.size() - n0, 0);
    chk("t1_frame", o_Frame, 64'h8877665544332211);
    chk("t1_locked_rowidx", {60'h0, o_Locked, o_RowIdx}, {60'h0, 1'b1, 3'd7});

    // reset mid-frame
    dwell(8'h01, 8'h99, 100);
    dwell(8'h02, 8'h98, 100);
    dwell(8'h04, 8'h97, 50);
    #3;
    i_Rst = 1'b1;
    #1;
    chk("midreset_frame", o_Frame, 64'h0);
    chk("midreset_lock_idx", {60'h0, o_Locked, o_RowIdx}, 64'h0);
    repeat (3) @(negedge i_Clk);
    i_Rst = 1'b0;

    // 2: start mid-scan, then three full frames
    n0 = err_q.size();
    f0 = ff_q.size();
    for (int k = 2; k < 8; k++) dwell(8'h01 << k, 8'h33, 100);
    chk_int("t2_no_frame_before_01", ff_q.size() - f0, 0);
    scan_frame(0, 1'b0, 1'b0);
    p_first = p01;
    scan_frame(0, 1'b0, 1'b0);
    scan_frame(0, 1'b0, 1'b0);
    chk_int("t2_frame_pulses", ff_q.size() - f0, 3);
    chk_int("t2_first_pulse", (ff_q.size() > f0) ? ff_q[f0] - p_first : -1, 719);
    chk_int("t2_period_a", (ff_q.size() > f0 + 1) ? ff_q[f0+1] - ff_q[f0] : -1, 800);
    chk_int("t2_period_b", (ff_q.size() > f0 + 2) ? ff_q[f0+2] - ff_q[f0+1] : -1, 800);
    chk_int("t2_no_errors", err_q.size() - n0, 0);

    // 3: order error 01,02,08
    n0 = err_q.size();
    dwell(8'h01, 8'hA0, 100);
    dwell(8'h02, 8'hA1, 100);
    dwell(8'h08, 8'hA3, 100);
    p_bad = last_p;
    chk_int("t3_err_count", err_q.size() - n0, 1);
    chk_int("t3_err_edge", (err_q.size() > n0) ? err_q[n0] - p_bad : -1, 18);
    chk("t3_unlocked", {63'h0, o_Locked}, 64'h0);
    chk("t3_frame_kept", o_Frame, 64'h8877665544332211);

    // 4: relock, then multi-hot row
    scan_frame(0, 1'b0, 1'b0);
    n0 = err_q.size();
    dwell(8'h03, 8'h55, 100);
    p_bad = last_p;
    chk_int("t4_err_edge", (err_q.size() > n0) ? err_q[n0] - p_bad : -1, 18);
    chk("t4_unlocked", {63'h0, o_Locked}, 64'h0);

    // 5: lock on 01,02 then hold 04 past the timeout
    dwell(8'h01, 8'h10, 100);
    dwell(8'h02, 8'h20, 100);
    n0 = err_q.size();
    dwell(8'h04, 8'h40, 1200);
    p_bad = last_p;
    chk_int("t5_err_count", err_q.size() - n0, 1);
    chk_int("t5_timeout_edge", (err_q.size() > n0) ? err_q[n0] - p_bad : -1, 1002);

    // 6: short glitch to row 6 early in the row-2 dwell
    n0 = err_q.size();
    scan_frame(1, 1'b0, 1'b1);
    repeat (5) @(negedge i_Clk);
    chk("t6_frame", o_Frame, 64'hC7C6C5C4C3C2C1C0);
    chk_int("t6_no_errors", err_q.size() - n0, 0);
    chk("t6_locked", {63'h0, o_Locked}, 64'h1);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
